alu_dispatch: RTL and testbench



---
 rtl/alu_dispatch.sv | 137 +++++++++++++
 tb/tb_alu_dispatch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch: buffers tagged ALU requests in a FIFO, issues them one at a time to the ALU
// and returns the captured result (or a timeout) with its tag over a response handshake.
package warp_pkg;
    localparam int DATA_WIDTH = 32;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_MAD
    } alu_opcode_e;
endpackage

module alu_dispatch #(
    parameter int DATA_WIDTH = warp_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  warp_pkg::alu_opcode_e req_opcode,
    input  logic [DATA_WIDTH-1:0] req_op1,
    input  logic [DATA_WIDTH-1:0] req_op2,
    input  logic [DATA_WIDTH-1:0] req_op3,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output warp_pkg::alu_opcode_e alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_operand1,
    output logic [DATA_WIDTH-1:0] alu_operand2,
    output logic [DATA_WIDTH-1:0] alu_operand3,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    typedef struct packed {
        warp_pkg::alu_opcode_e opcode;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [DATA_WIDTH-1:0] op3;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    state_e                state_q, state_d;
    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    entry_t                issue_q, issue_d;
    logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  ovf_q, ovf_d, tmo_q, tmo_d;
    logic                  empty, full, push, pop, expired;

    // Pointer MSB distinguishes full from empty when the index bits match
    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        push    = req_valid && !full;
        pop     = state_q == IDLE && !empty;
        expired = !alu_ready && cnt_q == 8'(TIMEOUT);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (alu_ready || expired) ? RESP : WAIT;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q + (AW+1)'(push);
        rd_d  = rd_q + (AW+1)'(pop);
        if (push) mem_d[wr_q[AW-1:0]] = '{opcode: req_opcode, op1: req_op1, op2: req_op2, op3: req_op3, tag: req_tag};
        issue_d = pop ? mem_q[rd_q[AW-1:0]] : issue_q;
        cnt_d   = state_q == ISSUE ? 8'd0 : (state_q == WAIT ? cnt_q + 8'd1 : cnt_q);
        res_d   = res_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        // A ready ALU wins over an expiring counter in the same cycle
        if (state_q == WAIT && (alu_ready || expired)) begin
            res_d = alu_ready ? alu_result : '0;
            ovf_d = alu_ready && alu_overflow;
            tmo_d = !alu_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            issue_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            issue_q <= issue_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_comb begin
        req_ready    = !full;
        rsp_valid    = state_q == RESP;
        busy         = state_q != IDLE || !empty;
        alu_opcode   = issue_q.opcode;
        alu_operand1 = issue_q.op1;
        alu_operand2 = issue_q.op2;
        alu_operand3 = issue_q.op3;
        rsp_tag      = issue_q.tag;
        rsp_result   = res_q;
        rsp_overflow = ovf_q;
        rsp_timeout  = tmo_q;
    end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed table-driven checks of alu_dispatch against an adder-style ALU stub.
module tb_alu_dispatch;
    import warp_pkg::*;

    localparam int TMO = 12;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0, req_ready;
    alu_opcode_e req_opcode = ALU_ADD;
    logic [31:0] req_op1 = 0, req_op2 = 0, req_op3 = 0;
    logic [3:0]  req_tag = 0;
    alu_opcode_e alu_opcode;
    logic [31:0] alu_operand1, alu_operand2, alu_operand3, alu_result;
    logic        alu_overflow, alu_ready = 0;
    logic        rsp_valid, rsp_ready = 1;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_timeout, busy;
    logic [3:0]  rsp_tag;

    int checks = 0;
    int failures = 0;

    alu_dispatch #(.DATA_WIDTH(32), .TAG_WIDTH(4), .DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_op1(req_op1), .req_op2(req_op2), .req_op3(req_op3), .req_tag(req_tag),
        .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_operand3(alu_operand3), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_ready(alu_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .rsp_tag(rsp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stub: 32-bit add with carry-out as overflow
    assign {alu_overflow, alu_result} = {1'b0, alu_operand1} + {1'b0, alu_operand2};

    typedef struct {
        alu_opcode_e opc;
        logic [31:0] a, b, c;
        logic [3:0]  tag;
        int          stall;
        logic [31:0] er;
        logic        eo, et;
        int          el;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1; req_tag = tag; req_op1 = a; req_op2 = b; req_op3 = 0; req_opcode = ALU_ADD;
        tick();
        req_valid = 0;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (!rsp_valid && n < 60) begin
            tick();
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_rsp required=rsp_valid", name);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int lat;
        logic stable;
        req_opcode = v.opc; req_op1 = v.a; req_op2 = v.b; req_op3 = v.c; req_tag = v.tag;
        req_valid = 1;
        rsp_ready = 1;
        alu_ready = (v.stall == 0);
        tick();
        req_valid = 0;
        lat = 1;
        stable = 1;
        while (!rsp_valid && lat < 200) begin
            if (v.stall > 0) alu_ready = (lat >= 3 + v.stall);
            tick();
            lat++;
            if (alu_operand1 !== v.a || alu_operand2 !== v.b || alu_operand3 !== v.c || alu_opcode !== v.opc) stable = 0;
        end
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.el));
        chk($sformatf("v%0d_result", idx), 64'(rsp_result), 64'(v.er));
        chk($sformatf("v%0d_overflow", idx), 64'(rsp_overflow), 64'(v.eo));
        chk($sformatf("v%0d_timeout", idx), 64'(rsp_timeout), 64'(v.et));
        chk($sformatf("v%0d_tag", idx), 64'(rsp_tag), 64'(v.tag));
        chk($sformatf("v%0d_alu_stable", idx), 64'(stable), 64'd1);
        tick();
        chk($sformatf("v%0d_idle_after", idx), 64'({rsp_valid, busy}), 64'd0);
    endtask

    initial begin
        logic held, stale;
        vecs[0] = '{ALU_ADD, 32'd5, 32'd7, 32'd0, 4'd3, 0, 32'd12, 1'b0, 1'b0, 4};
        vecs[1] = '{ALU_SUB, 32'hFFFF_FFFF, 32'd2, 32'd9, 4'd9, 0, 32'd1, 1'b1, 1'b0, 4};
        vecs[2] = '{ALU_MUL, 32'd100, 32'd23, 32'd1, 4'd5, 10, 32'd123, 1'b0, 1'b0, 14};
        vecs[3] = '{ALU_XOR, 32'd1, 32'd1, 32'd2, 4'd7, 99, 32'd0, 1'b0, 1'b1, 16};
        vecs[4] = '{ALU_ADD, 32'd40, 32'd2, 32'd0, 4'd15, 0, 32'd42, 1'b0, 1'b0, 4};
        vecs[5] = '{ALU_MAD, 32'd8, 32'd9, 32'd3, 4'd2, TMO, 32'd17, 1'b0, 1'b0, 16};

        repeat (3) tick();
        rst = 0;
        tick();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_alu_opcode", 64'(alu_opcode), 64'd0);
        chk("reset_alu_operands", 64'({alu_operand1, alu_operand2} | 64'(alu_operand3)), 64'd0);

        for (int i = 0; i < 6; i++) run_op(vecs[i], i);

        // Full FIFO: one op in flight plus DEPTH buffered, responses held back
        rsp_ready = 0;
        alu_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill%0d_req_ready", i), 64'(req_ready), 64'd1);
            push(4'(i), 32'(i), 32'd10);
        end
        chk("full_req_ready", 64'(req_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        req_valid = 1; req_tag = 4'd6; req_op1 = 32'd66;
        repeat (3) tick();
        req_valid = 0;
        chk("full_still_refusing", 64'(req_ready), 64'd0);
        rsp_ready = 1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp($sformatf("drain%0d", k));
            chk($sformatf("drain%0d_tag", k), 64'(rsp_tag), 64'(k));
            chk($sformatf("drain%0d_result", k), 64'(rsp_result), 64'(10 + k));
            tick();
        end
        chk("drain_busy_low", 64'(busy), 64'd0);
        stale = 0;
        repeat (6) begin
            tick();
            if (rsp_valid) stale = 1;
        end
        chk("drain_no_extra_rsp", 64'(stale), 64'd0);

        // Backpressure in RESP for 5 cycles with a second op queued behind
        rsp_ready = 0;
        alu_ready = 1;
        push(4'd6, 32'd3, 32'd4);
        push(4'd8, 32'd20, 32'd22);
        wait_rsp("bp_first");
        chk("bp_first_tag", 64'(rsp_tag), 64'd6);
        chk("bp_first_result", 64'(rsp_result), 64'd7);
        held = 1;
        repeat (5) begin
            tick();
            if (!rsp_valid || rsp_tag !== 4'd6 || rsp_result !== 32'd7 || alu_operand1 !== 32'd3) held = 0;
        end
        chk("bp_held", 64'(held), 64'd1);
        rsp_ready = 1;
        tick();
        chk("bp_idle_after_hs", 64'(rsp_valid), 64'd0);
        chk("bp_busy_queued", 64'(busy), 64'd1);
        tick();
        chk("bp_next_issue", 64'(alu_operand1), 64'd20);
        wait_rsp("bp_second");
        chk("bp_second_tag", 64'(rsp_tag), 64'd8);
        chk("bp_second_result", 64'(rsp_result), 64'd42);
        tick();

        // Reset mid-WAIT with two entries buffered
        alu_ready = 0;
        rsp_ready = 1;
        push(4'd1, 32'd11, 32'd1);
        push(4'd2, 32'd12, 32'd1);
        push(4'd3, 32'd13, 32'd1);
        repeat (3) tick();
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_alu_zero", 64'({alu_operand1, alu_operand2} | 64'(alu_operand3) | 64'(alu_opcode)), 64'd0);
        alu_ready = 1;
        stale = 0;
        repeat (10) begin
            tick();
            if (rsp_valid || busy) stale = 1;
        end
        chk("rst_no_stale", 64'(stale), 64'd0);
        run_op(vecs[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
